// File: rtl/imem_access_arbiter_if.sv
// Bundle of the fetch, loader and memory-side signals for imem_access_arbiter.
// master = requesters plus memory model, slave = the arbiter itself.
interface imem_access_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  // Handshake: a requester raises *_req with stable address/data and holds it
  // until *_gnt is seen high in the same cycle; the response (*_rvalid) follows
  // exactly one cycle after the grant, with no backpressure on the response.
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              f_err;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_lock;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  logic              l_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              lock_active;

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, lock_active
  );

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output mem_en, mem_we, mem_addr, mem_wdata, lock_active
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// Single-port instruction memory arbiter: fetch has priority, the loader is
// forced through after STARVE_MAX contended losses, and l_lock excludes fetch.
module imem_access_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_access_arbiter_if.slave  bus
);

  typedef enum logic {RUN = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] DEPTH_A    = ADDR_W'(DEPTH);
  localparam logic [DATA_W-1:0] ZERO_D     = '0;

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              f_gnt_c, l_gnt_c;
  logic              f_bad, l_bad;
  logic              tag_f_q, tag_l_q, tag_err_q, tag_we_q;
  logic              mem_en_c, mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  assign f_bad = (bus.f_addr[1:0] != 2'b00) || (bus.f_addr >= DEPTH_A);
  assign l_bad = (bus.l_addr[1:0] != 2'b00) || (bus.l_addr >= DEPTH_A);

  // Grants are gated by reset so nothing is issued while reset is held.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    f_gnt_c  = 1'b0;
    l_gnt_c  = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (bus.f_req && bus.l_req) begin
            if (starve_q == STARVE_LIM) l_gnt_c = 1'b1;
            else                        f_gnt_c = 1'b1;
          end else begin
            f_gnt_c = bus.f_req;
            l_gnt_c = bus.l_req;
          end
          if (f_gnt_c && bus.l_req)
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
          else
            starve_d = 4'd0;
          if (bus.l_lock) state_d = LOCKED;
        end
        LOCKED: begin
          l_gnt_c  = bus.l_req;
          starve_d = 4'd0;
          if (!bus.l_lock) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Error requests are granted but never reach the memory.
  always_comb begin
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (f_gnt_c && !f_bad) begin
      mem_en_c   = 1'b1;
      mem_addr_c = bus.f_addr;
    end else if (l_gnt_c && !l_bad) begin
      mem_en_c    = 1'b1;
      mem_we_c    = bus.l_we;
      mem_addr_c  = bus.l_addr;
      mem_wdata_c = bus.l_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      starve_q  <= 4'd0;
      tag_f_q   <= 1'b0;
      tag_l_q   <= 1'b0;
      tag_err_q <= 1'b0;
      tag_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      tag_f_q   <= f_gnt_c;
      tag_l_q   <= l_gnt_c;
      tag_err_q <= f_gnt_c ? f_bad : l_bad;
      tag_we_q  <= l_gnt_c && bus.l_we;
    end
  end

  assign bus.f_gnt     = f_gnt_c;
  assign bus.l_gnt     = l_gnt_c;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  // Response side: the tags say whose memory data is on mem_rdata this cycle.
  assign bus.f_rvalid  = tag_f_q;
  assign bus.f_err     = tag_f_q && tag_err_q;
  assign bus.f_rdata   = (tag_f_q && !tag_err_q) ? bus.mem_rdata : ZERO_D;
  assign bus.l_rvalid  = tag_l_q;
  assign bus.l_err     = tag_l_q && tag_err_q;
  assign bus.l_rdata   = (tag_l_q && !tag_err_q && !tag_we_q) ? bus.mem_rdata : ZERO_D;

  assign bus.lock_active = (state_q == LOCKED);

endmodule
